// File: rtl/wallace_mul_seq.sv
// Sequencer for a 2W x 2W unsigned multiply. It time-shares one external W x W core
// over four partial-product passes and accumulates the passes into a 4W-bit result.
module wallace_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic [W-1:0]   core_a,
  output logic [W-1:0]   core_b,
  input  logic [2*W-1:0] core_p,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [4*W-1:0] rsp_p,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] ra, rb;
  logic [4*W-1:0] acc, acc_nxt, rsp_q;
  logic [4*W-1:0] pp_mid, pp_hi;
  logic           accept;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_p     = rsp_q;

  // Cross terms land at bit W; the high x high term lands at bit 2W.
  assign pp_mid = {{W{1'b0}}, core_p, {W{1'b0}}};
  assign pp_hi  = {core_p, {(2*W){1'b0}}};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    core_a    = '0;
    core_b    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_a == '0 || req_b == '0) begin
            acc_nxt   = '0;
            state_nxt = DONE;
          end else begin
            state_nxt = P0;
          end
        end
      end
      P0: begin
        core_a    = ra[W-1:0];
        core_b    = rb[W-1:0];
        acc_nxt   = {{(2*W){1'b0}}, core_p};
        state_nxt = P1;
      end
      P1: begin
        core_a    = ra[W-1:0];
        core_b    = rb[2*W-1:W];
        acc_nxt   = acc + pp_mid;
        state_nxt = P2;
      end
      P2: begin
        core_a    = ra[2*W-1:W];
        core_b    = rb[W-1:0];
        acc_nxt   = acc + pp_mid;
        state_nxt = P3;
      end
      P3: begin
        core_a    = ra[2*W-1:W];
        core_b    = rb[2*W-1:W];
        acc_nxt   = acc + pp_hi;
        state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (accept) begin
        ra <= req_a;
        rb <= req_b;
      end
      // Response register only moves on entry to DONE, so it holds through stalls and IDLE.
      if (state != DONE && state_nxt == DONE) rsp_q <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_wallace_mul_seq.sv
// Self-checking bench for wallace_mul_seq: models the W x W core and compares each
// response against a plain a*b product, plus latency/throughput/handshake rules.
module tb_wallace_mul_seq;
  localparam int W = 8;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           req_valid = 0;
  logic           req_ready;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0]   core_a, core_b;
  logic [2*W-1:0] core_p;
  logic           rsp_valid;
  logic           rsp_ready = 0;
  logic [4*W-1:0] rsp_p;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit idle_toggle = 0;
  logic [2*W-1:0] pair_q[$];
  int acc_cyc_q[$];

  wallace_mul_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .core_a(core_a), .core_b(core_b), .core_p(core_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .busy(busy)
  );

  // Behavioural stand-in for the Wallace-tree core.
  assign core_p = core_a * core_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && busy && !rsp_valid) pair_q.push_back({core_a, core_b});
    if (rst_n && (!busy || rsp_valid) && (core_a != '0 || core_b != '0)) idle_toggle = 1;
    if (rst_n && req_valid && req_ready) acc_cyc_q.push_back(cyc);
  end

  // Caller enters just after a rising edge. lat counts edges from the accepting cycle's
  // opening edge to the cycle where rsp_valid is seen (5 normal, 1 zero-skip).
  task automatic run_txn(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                         output logic [4*W-1:0] p, output int lat, output bit to);
    int n;
    req_a = a; req_b = b; req_valid = 1; rsp_ready = 1; to = 0; lat = 0; p = '0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin to = 1; req_valid = 0; return; end
    @(posedge clk); #1 req_valid = 0; lat = 1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(posedge clk); lat++; @(negedge clk); n++; end
    if (!rsp_valid) to = 1;
    p = rsp_p;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== '0 || busy !== 1'b0 || core_a !== '0 || core_b !== '0) begin
      failures++;
      $display("FAIL reset_during: rsp_valid=%b rsp_p=%h busy=%b core=%h/%h required 0", rsp_valid, rsp_p, busy, core_a, core_b);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_p !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b rsp_p=%h busy=%b required 1/0/0/0", req_ready, rsp_valid, rsp_p, busy);
    end
  endtask

  task automatic test_basic();
    logic [4*W-1:0] p; int lat; bit to;
    logic [2*W-1:0] a, b, exp_pairs[4];
    a = 16'h1234; b = 16'h5678;
    exp_pairs[0] = {a[7:0], b[7:0]};  exp_pairs[1] = {a[7:0], b[15:8]};
    exp_pairs[2] = {a[15:8], b[7:0]}; exp_pairs[3] = {a[15:8], b[15:8]};
    pair_q.delete();
    run_txn(a, b, p, lat, to);
    checks++;
    if (to || p !== 32'h06260060) begin
      failures++; $display("FAIL basic_product: got %h timeout=%0b required 06260060", p, to);
    end
    checks++;
    if (lat != 5) begin failures++; $display("FAIL basic_latency: got %0d required 5", lat); end
    checks++;
    if (pair_q.size() != 4) begin
      failures++; $display("FAIL basic_pass_count: got %0d required 4", pair_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pair_q[i] !== exp_pairs[i]) begin
          failures++; $display("FAIL basic_core_pair%0d: got %h required %h", i, pair_q[i], exp_pairs[i]);
        end
      end
    end
  endtask

  task automatic test_max();
    logic [4*W-1:0] p; int lat; bit to;
    run_txn(16'hFFFF, 16'hFFFF, p, lat, to);
    checks++;
    if (to || p !== 32'hFFFE0001) begin
      failures++; $display("FAIL max_product: got %h timeout=%0b required fffe0001", p, to);
    end
  endtask

  task automatic test_zero_skip();
    logic [4*W-1:0] p; int lat; bit to;
    idle_toggle = 0;
    pair_q.delete();
    run_txn(16'h0000, 16'hABCD, p, lat, to);
    checks++;
    if (to || p !== '0 || lat != 1) begin
      failures++; $display("FAIL zero_skip: got p=%h lat=%0d required 0 and 1", p, lat);
    end
    checks++;
    if (idle_toggle || pair_q.size() != 0) begin
      failures++; $display("FAIL zero_core_quiet: toggle=%0b passes=%0d required 0/0", idle_toggle, pair_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [4*W-1:0] p;
    req_a = 16'h0003; req_b = 16'h0007; req_valid = 1; rsp_ready = 0;
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    // New request waits while the response stalls.
    req_a = 16'h0005; req_b = 16'h0009; req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== 32'h15 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: rsp_valid=%b rsp_p=%h req_ready=%b required 1/15/0", i, rsp_valid, rsp_p, req_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_p !== 32'h15) begin
      failures++;
      $display("FAIL bp_idle: req_ready=%b rsp_valid=%b rsp_p=%h required 1/0/15", req_ready, rsp_valid, rsp_p);
    end
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    p = rsp_p;
    checks++;
    if (rsp_valid !== 1'b1 || p !== 32'd45) begin
      failures++; $display("FAIL bp_next: got %h valid=%b required 2d", p, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [4*W-1:0] p; int lat; bit to;
    req_a = 16'hAB12; req_b = 16'hCD34; req_valid = 1; rsp_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== '0 || busy !== 1'b0 || core_a !== '0 || core_b !== '0) begin
      failures++;
      $display("FAIL reset_mid: rsp_valid=%b rsp_p=%h busy=%b core=%h/%h required 0", rsp_valid, rsp_p, busy, core_a, core_b);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    run_txn(16'h0002, 16'h0003, p, lat, to);
    checks++;
    if (to || p !== 32'h6) begin
      failures++; $display("FAIL reset_mid_after: got %h required 6", p);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] as[2], bs[2];
    logic [4*W-1:0] exp_q[$], got_q[$];
    int idx, n;
    bit acc_now;
    as[0] = 16'h00FF; bs[0] = 16'h0100; as[1] = 16'h8000; bs[1] = 16'h0002;
    acc_cyc_q.delete();
    idx = 0;
    req_a = as[0]; req_b = bs[0]; req_valid = 1; rsp_ready = 1;
    n = 0;
    while (got_q.size() < 4 && n < 100) begin
      @(negedge clk);
      acc_now = req_valid && req_ready;
      if (acc_now && exp_q.size() < 4) exp_q.push_back(32'(req_a) * 32'(req_b));
      if (rsp_valid) got_q.push_back(rsp_p);
      @(posedge clk); #1;
      if (acc_now) begin idx = 1 - idx; req_a = as[idx]; req_b = bs[idx]; end
      n++;
    end
    req_valid = 0;
    checks++;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL b2b_count: got %0d required 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL b2b_result%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < acc_cyc_q.size() && i < 4; i++) begin
      checks++;
      if (acc_cyc_q[i] - acc_cyc_q[i-1] != 6) begin
        failures++; $display("FAIL b2b_interval%0d: got %0d required 6", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
      end
    end
    repeat (8) @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [4*W-1:0] p, exp; int lat; bit to;
    logic [2*W-1:0] a, b;
    idle_toggle = 0;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = '0;
      exp = 32'(a) * 32'(b);
      run_txn(a, b, p, lat, to);
      checks++;
      if (to || p !== exp || lat != ((a == '0 || b == '0) ? 1 : 5)) begin
        failures++; $display("FAIL rand%0d %h*%h: got %h lat=%0d required %h", i, a, b, p, lat, exp);
      end
    end
    checks++;
    if (idle_toggle) begin failures++; $display("FAIL rand_core_quiet: core toggled while idle"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_skip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
